// File: rtl/regfile_access_seq.sv
// Initiator for a level-sensitive register bank: queues read-pair/write commands in an
// in-order FIFO and sequences glitch-safe bank cycles. Option: REGSEQ_WRITE_ACK_EN.
module regfile_access_seq #(
   parameter int DEPTH = 4,
   parameter int AW    = 5,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_wr,
   input  logic [AW-1:0] cmd_a,
   input  logic [AW-1:0] cmd_b,
   input  logic [DW-1:0] cmd_wd,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_d1,
   output logic [DW-1:0] rsp_d2,
   output logic          RegEn,
   output logic [AW-1:0] RR1,
   output logic [AW-1:0] RR2,
   output logic [AW-1:0] WA,
   output logic [DW-1:0] WD,
   input  logic [DW-1:0] DR1,
   input  logic [DW-1:0] DR2,
   output logic          busy
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD, S_RD_ADDR, S_RD_CAP, S_RSP
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;
   logic          cmd_ready_q, cmd_ready_d;
   logic          busy_q, busy_d;
   logic          regen_q, regen_d;
   logic [AW-1:0] rr1_q, rr1_d, rr2_q, rr2_d, wa_q, wa_d;
   logic [DW-1:0] wd_q, wd_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [DW-1:0] rsp_d1_q, rsp_d1_d, rsp_d2_q, rsp_d2_d;
   logic          push_s, pop_s;

   logic          fifo_wr_q [DEPTH];
   logic [AW-1:0] fifo_a_q  [DEPTH];
   logic [AW-1:0] fifo_b_q  [DEPTH];
   logic [DW-1:0] fifo_wd_q [DEPTH];

   // Pop is based on the registered count, so an entry pushed into an empty FIFO
   // is never popped in the same cycle.
   always_comb begin
      push_s = cmd_valid && cmd_ready_q;
      pop_s  = (state_q == S_IDLE) && (count_q != '0);

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + (PW+1)'(1);
         2'b01:   count_d = count_q - (PW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Sequencer next state; address/data registers double as the working register.
   always_comb begin
      state_d     = state_q;
      regen_d     = 1'b0;
      rr1_d       = rr1_q;
      rr2_d       = rr2_q;
      wa_d        = wa_q;
      wd_d        = wd_q;
      rsp_valid_d = rsp_valid_q;
      rsp_d1_d    = rsp_d1_q;
      rsp_d2_d    = rsp_d2_q;
      case (state_q)
         S_IDLE: begin
            if (pop_s) begin
               if (fifo_wr_q[rd_ptr_q]) begin
                  state_d = S_WR_SETUP;
                  wa_d    = fifo_a_q[rd_ptr_q];
                  wd_d    = fifo_wd_q[rd_ptr_q];
               end else begin
                  state_d = S_RD_ADDR;
                  rr1_d   = fifo_a_q[rd_ptr_q];
                  rr2_d   = fifo_b_q[rd_ptr_q];
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WR_SETUP: begin
            state_d = S_WR_PULSE;
            regen_d = 1'b1;
         end
         S_WR_PULSE: state_d = S_WR_HOLD;
         S_WR_HOLD: begin
`ifdef REGSEQ_WRITE_ACK_EN
            state_d     = S_RSP;
            rsp_valid_d = 1'b1;
            rsp_d1_d    = wd_q;
            rsp_d2_d    = '0;
`else
            state_d = S_IDLE;
`endif
         end
         S_RD_ADDR: state_d = S_RD_CAP;
         S_RD_CAP: begin
            state_d     = S_RSP;
            rsp_valid_d = 1'b1;
            rsp_d1_d    = DR1;
            rsp_d2_d    = DR2;
         end
         S_RSP: begin
            if (rsp_ready) begin
               state_d     = S_IDLE;
               rsp_valid_d = 1'b0;
            end else begin
               state_d = S_RSP;
            end
         end
         default: begin
            state_d     = S_IDLE;
            rsp_valid_d = 1'b0;
         end
      endcase
      cmd_ready_d = (count_d != FULL_CNT);
      busy_d      = (count_d != '0) || (state_d != S_IDLE);
   end

   // State and registered outputs; reset also drops RegEn immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         cmd_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         regen_q     <= 1'b0;
         rr1_q       <= '0;
         rr2_q       <= '0;
         wa_q        <= '0;
         wd_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_d1_q    <= '0;
         rsp_d2_q    <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         cmd_ready_q <= cmd_ready_d;
         busy_q      <= busy_d;
         regen_q     <= regen_d;
         rr1_q       <= rr1_d;
         rr2_q       <= rr2_d;
         wa_q        <= wa_d;
         wd_q        <= wd_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_d1_q    <= rsp_d1_d;
         rsp_d2_q    <= rsp_d2_d;
      end
   end

   // Command storage; stale contents are harmless since the count gates reads.
   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_wr_q[wr_ptr_q] <= cmd_wr;
         fifo_a_q[wr_ptr_q]  <= cmd_a;
         fifo_b_q[wr_ptr_q]  <= cmd_b;
         fifo_wd_q[wr_ptr_q] <= cmd_wd;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign busy      = busy_q;
   assign RegEn     = regen_q;
   assign RR1       = rr1_q;
   assign RR2       = rr2_q;
   assign WA        = wa_q;
   assign WD        = wd_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_d1    = rsp_d1_q;
   assign rsp_d2    = rsp_d2_q;

endmodule
